stream_demux_1to2: RTL and testbench

//   Packet-aware 1-to-2 stream demultiplexer with valid/ready handshakes.
//   It routes each input packet to one of two output streams, chosen by in_sel on the packet's first beat.
//   One register stage per output gives a 1-cycle latency.

---
 rtl/stream_demux_1to2.sv | 128 ++++++++++++
 tb/tb_stream_demux_1to2.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1to2.sv
// Packet-aware 1-to-2 stream demultiplexer with valid/ready handshakes.
// The destination is taken from in_sel on the head beat and held for the rest of
// the packet. Each output has one register stage, so latency is one cycle.
// Each output also keeps a count of completed packets.

module stream_demux_1to2 #(
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,

    input  logic [W-1:0]     in_data,
    input  logic             in_sel,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,

    output logic [W-1:0]     out0_data,
    output logic             out0_last,
    output logic             out0_valid,
    input  logic             out0_ready,

    output logic [W-1:0]     out1_data,
    output logic             out1_last,
    output logic             out1_valid,
    input  logic             out1_ready,

    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    typedef enum logic {
        StIdle,
        StBusy
    } state_t;

    state_t state_q, state_d;
    logic   sel_q, sel_d;
    logic   route;
    logic   accept;
    logic   load0, load1;

    // Routing, handshake and next-state decode.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;

        // in_sel only matters on a head beat; inside a packet the latched choice wins.
        route    = (state_q == StIdle) ? in_sel : sel_q;
        in_ready = route ? (~out1_valid | out1_ready) : (~out0_valid | out0_ready);
        accept   = in_valid & in_ready;
        load0    = accept & ~route;
        load1    = accept & route;

        case (state_q)
            StIdle: begin
                if (accept && !in_last) begin
                    state_d = StBusy;
                    sel_d   = in_sel;
                end
            end
            StBusy: begin
                if (accept && in_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Packet state and latched destination; reset drops any partial packet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Output register 0: a load wins over a drain so full rate is sustained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out0_valid <= 1'b0;
            out0_data  <= '0;
            out0_last  <= 1'b0;
        end else if (load0) begin
            out0_valid <= 1'b1;
            out0_data  <= in_data;
            out0_last  <= in_last;
        end else if (out0_ready) begin
            out0_valid <= 1'b0;
        end
    end

    // Output register 1: same behaviour as output 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out1_valid <= 1'b0;
            out1_data  <= '0;
            out1_last  <= 1'b0;
        end else if (load1) begin
            out1_valid <= 1'b1;
            out1_data  <= in_data;
            out1_last  <= in_last;
        end else if (out1_ready) begin
            out1_valid <= 1'b0;
        end
    end

    // Packet counters bump when a last beat enters its output register; they wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_cnt0 <= '0;
            pkt_cnt1 <= '0;
        end else begin
            if (load0 && in_last) begin
                pkt_cnt0 <= pkt_cnt0 + CNT_W'(1);
            end
            if (load1 && in_last) begin
                pkt_cnt1 <= pkt_cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_demux_1to2.sv
// Self-checking bench for stream_demux_1to2: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.

module tb_stream_demux_1to2;

    localparam int unsigned W     = 8;
    localparam int unsigned CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [W-1:0]     in_data = '0;
    logic             in_sel = 1'b0;
    logic             in_last = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [W-1:0]     out0_data, out1_data;
    logic             out0_last, out1_last;
    logic             out0_valid, out1_valid;
    logic             out0_ready = 1'b1;
    logic             out1_ready = 1'b1;
    logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;

    int checks = 0;
    int errors = 0;

    stream_demux_1to2 #(
        .W     (W),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_last  (out0_last),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_last  (out1_last),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: one slot per output, packet tracking, counters, and
    // per-output queues of every beat that must eventually drain.
    logic             m_v [2];
    logic [W-1:0]     m_d [2];
    logic             m_l [2];
    logic [CNT_W-1:0] m_cnt [2];
    logic             m_busy, m_sel, m_acc;
    logic [W:0]       q0 [$];
    logic [W:0]       q1 [$];

    initial begin
        forever begin
            logic r, acc;
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int n = 0; n < 2; n++) begin
                    m_v[n] = 1'b0; m_d[n] = '0; m_l[n] = 1'b0; m_cnt[n] = '0;
                end
                m_busy = 1'b0; m_sel = 1'b0; m_acc = 1'b0;
                q0.delete(); q1.delete();
            end else begin
                r   = m_busy ? m_sel : in_sel;
                acc = in_valid && (!m_v[r] || (r ? out1_ready : out0_ready));
                m_acc = acc;
                if (m_v[0] && out0_ready) m_v[0] = 1'b0;
                if (m_v[1] && out1_ready) m_v[1] = 1'b0;
                if (acc) begin
                    m_v[r] = 1'b1;
                    m_d[r] = in_data;
                    m_l[r] = in_last;
                    if (r) q1.push_back({in_last, in_data});
                    else   q0.push_back({in_last, in_data});
                    if (in_last) begin
                        m_cnt[r] = m_cnt[r] + 1'b1;
                        m_busy   = 1'b0;
                    end else if (!m_busy) begin
                        m_busy = 1'b1;
                        m_sel  = in_sel;
                    end
                end
            end
        end
    end

    // Compare process: on each falling edge, outputs against the model and
    // drained beats against the per-output order queues.
    initial begin
        forever begin
            logic r;
            @(negedge clk);
            if (!rst) begin
                r = m_busy ? m_sel : in_sel;
                chk("in_ready", in_ready, !m_v[r] || (r ? out1_ready : out0_ready));
                chk("out0_valid", out0_valid, m_v[0]);
                chk("out1_valid", out1_valid, m_v[1]);
                chk("out0_beat", {out0_last, out0_data}, {m_l[0], m_d[0]});
                chk("out1_beat", {out1_last, out1_data}, {m_l[1], m_d[1]});
                chk("pkt_cnt0", pkt_cnt0, m_cnt[0]);
                chk("pkt_cnt1", pkt_cnt1, m_cnt[1]);
                if (m_v[0] && out0_ready) begin
                    if (q0.size() == 0) chk("order0_empty", 1, 0);
                    else chk("order0", {out0_last, out0_data}, q0.pop_front());
                end
                if (m_v[1] && out1_ready) begin
                    if (q1.size() == 0) chk("order1_empty", 1, 0);
                    else chk("order1", {out1_last, out1_data}, q1.pop_front());
                end
            end
        end
    end

    // Present one beat and return 1 time unit after the edge that accepts it.
    task automatic send(input logic [W-1:0] d, input logic s, input logic l);
        bit ok = 1'b0;
        in_data = d; in_sel = s; in_last = l; in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            #1;
        end else begin
            chk("send_timeout", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    // Reset pulse placed away from the rising edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // 1. power-on reset, then an asynchronous reset over a held beat
        #12 rst = 1'b0;
        @(posedge clk); #1;
        chk("t1_ready", in_ready, 1);
        chk("t1_out0_valid", out0_valid, 0);
        chk("t1_out1_valid", out1_valid, 0);
        out0_ready = 1'b0;
        send(8'h99, 1'b0, 1'b1);
        chk("t1_held", {out0_valid, out0_data}, 9'h199);
        chk("t1_cnt_pre", pkt_cnt0, 1);
        #2 rst = 1'b1;
        #1;
        chk("t1_async_valid", out0_valid, 0);
        chk("t1_async_beat", {out0_last, out0_data}, 0);
        chk("t1_async_cnt", pkt_cnt0, 0);
        #2 rst = 1'b0;
        out0_ready = 1'b1;
        @(posedge clk); #1;
        chk("t1_ready_post", in_ready, 1);

        // 2. single-beat packets to each output
        send(8'hA5, 1'b0, 1'b1);
        chk("t2_out0", {out0_valid, out0_last, out0_data}, 10'h3A5);
        send(8'h3C, 1'b1, 1'b1);
        chk("t2_out1", {out1_valid, out1_last, out1_data}, 10'h33C);
        chk("t2_out0_drained", out0_valid, 0);
        chk("t2_cnt0", pkt_cnt0, 1);
        chk("t2_cnt1", pkt_cnt1, 1);

        // 3. 4-beat packet; in_sel flips after the head and must be ignored
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            send(W'(k), (k != 1), (k == 4));
            chk("t3_beat", {out0_valid, out0_data}, {1'b1, W'(k)});
            chk("t3_out1_idle", out1_valid, 0);
        end
        chk("t3_last", out0_last, 1);
        chk("t3_cnt0", pkt_cnt0, 1);
        chk("t3_cnt1", pkt_cnt1, 0);

        // 4. out0 stalled: second beat waits, then goes the cycle ready rises
        do_reset();
        out0_ready = 1'b0;
        send(8'h11, 1'b0, 1'b1);
        chk("t4_first", out0_data, 8'h11);
        in_data = 8'h22; in_sel = 1'b0; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("t4_blocked", in_ready, 0);
        @(posedge clk); #1;
        out0_ready = 1'b1;
        #1;
        chk("t4_unblocked", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out0_ready = 1'b0;
        chk("t4_second", {out0_valid, out0_data}, 9'h122);

        // 5. out0 still holds 22; a packet for out1 passes straight through
        in_data = 8'h77; in_sel = 1'b1; in_last = 1'b1; in_valid = 1'b1;
        #1;
        chk("t5_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t5_out1", {out1_valid, out1_data}, 9'h177);
        chk("t5_out0_held", {out0_valid, out0_data}, 9'h122);
        out0_ready = 1'b1;

        // 6. counter wrap, then reset mid-packet
        do_reset();
        for (int k = 0; k < 5; k++) send(W'(8'h40 + k), 1'b1, 1'b1);
        chk("t6_wrap", pkt_cnt1, 1);
        send(8'hA0, 1'b0, 1'b0);
        in_data = 8'hA1; in_sel = 1'b1; in_last = 1'b0; in_valid = 1'b1;
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("t6_out0_cleared", out0_valid, 0);
        send(8'hB2, 1'b1, 1'b1);
        chk("t6_new_head", {out1_valid, out1_data}, 9'h1B2);
        chk("t6_out0_idle", out0_valid, 0);

        // Random traffic; a stalled beat is held stable until accepted
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!(in_valid && !m_acc)) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = W'($urandom);
                in_sel   = 1'($urandom);
                in_last  = ($urandom_range(0, 2) == 0);
            end
            out0_ready = ($urandom_range(0, 3) != 0);
            out1_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
